// File: rtl/uart_response_tx.sv
// rtl/uart_response_tx.sv - serialises completed bus reads as ASCII "Dhhhh\r\n" on a UART tx pin
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   data_i  in   [15:0] read data returned by the bus
//   rw_i    in   1 = write (ignored), 0 = read (produces a response)
//   valid_i in   bus transaction completes this cycle
//   busy_o  out  response in flight; further requests are dropped
//   tx      out  UART serial output, idle high
module uart_response_tx #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        busy_o,
    output logic        tx
);

    localparam int BW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    logic [15:0]   data;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    byte_idx;
    logic [3:0]    bit_idx;
    logic [7:0]    cur_byte;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F' ('A' - 10 = 0x37)
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = 8'h44;
            3'd1:    cur_byte = hex_ascii(data[15:12]);
            3'd2:    cur_byte = hex_ascii(data[11:8]);
            3'd3:    cur_byte = hex_ascii(data[7:4]);
            3'd4:    cur_byte = hex_ascii(data[3:0]);
            3'd5:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // tx is driven one cycle ahead of the bit it represents, so every
    // transition below loads the value for the bit that starts next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data     <= 16'h0000;
            baud_cnt <= '0;
            byte_idx <= 3'd0;
            bit_idx  <= 4'd0;
            busy_o   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx     <= 1'b1;
                    busy_o <= 1'b0;
                    if (valid_i && !rw_i) begin
                        state    <= SEND;
                        data     <= data_i;
                        baud_cnt <= '0;
                        byte_idx <= 3'd0;
                        bit_idx  <= 4'd0;
                        busy_o   <= 1'b1;
                        tx       <= 1'b0;
                    end
                end
                SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= 4'd0;
                            if (byte_idx == 3'd6) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                                tx     <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                tx       <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            // leaving bit 8 (data MSB) enters the stop bit
                            tx <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    tx     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_response_tx.sv
// tb/tb_uart_response_tx.sv - directed self-checking bench for uart_response_tx
module tb_uart_response_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = 16'h0000;
    logic        rw = 1'b0;
    logic        valid = 1'b0;
    logic        sel = 1'b0;   // 0: CLOCKS_PER_BAUD=4 instance, 1: =2 instance

    logic busy4, tx4, busy2, tx2;
    logic valid4, valid2, busy_s, tx_s;

    assign valid4 = valid & ~sel;
    assign valid2 = valid & sel;
    assign busy_s = sel ? busy2 : busy4;
    assign tx_s   = sel ? tx2 : tx4;

    uart_response_tx #(.CLOCKS_PER_BAUD(4)) dut4 (
        .clk(clk), .rst(rst), .data_i(data), .rw_i(rw), .valid_i(valid4),
        .busy_o(busy4), .tx(tx4)
    );

    uart_response_tx #(.CLOCKS_PER_BAUD(2)) dut2 (
        .clk(clk), .rst(rst), .data_i(data), .rw_i(rw), .valid_i(valid2),
        .busy_o(busy2), .tx(tx2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_bytes [7];
    int         busy_len;
    bit         frame_ok;
    bit         width_ok;
    logic       first_tx;
    logic       first_busy;
    logic       end_tx;

    // Called at a negedge; request is accepted at the following posedge and
    // the task returns at the negedge of the first busy cycle.
    task automatic drive_read(input logic [15:0] d);
        data  = d;
        rw    = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Records tx for every busy cycle, then decodes it as 8N1 frames.
    task automatic capture();
        logic q[$];
        int   cpb;
        int   base;
        logic b;
        cpb = sel ? 2 : 4;
        q = {};
        first_tx   = tx_s;
        first_busy = busy_s;
        while (busy_s === 1'b1 && q.size() < 2000) begin
            q.push_back(tx_s);
            @(negedge clk);
        end
        busy_len = q.size();
        end_tx   = tx_s;
        frame_ok = 1'b1;
        width_ok = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rx_bytes[k] = 8'hxx;
            for (int j = 0; j < 10; j++) begin
                base = (k * 10 + j) * cpb;
                if (base + cpb > q.size()) begin
                    frame_ok = 1'b0;
                    width_ok = 1'b0;
                end else begin
                    b = q[base];
                    for (int m = 1; m < cpb; m++)
                        if (q[base + m] !== b) width_ok = 1'b0;
                    if (j == 0 && b !== 1'b0) frame_ok = 1'b0;
                    if (j == 9 && b !== 1'b1) frame_ok = 1'b0;
                    if (j >= 1 && j <= 8) rx_bytes[k][j-1] = b;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpb4: tx=%b busy=%b, required tx=1 busy=0", tx4, busy4);
        end
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpb2: tx=%b busy=%b, required tx=1 busy=0", tx2, busy2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_patterns();
        logic [15:0] vec_d [4];
        logic [55:0] vec_e [4];
        logic [55:0] e;
        vec_d[0] = 16'h1234; vec_e[0] = {8'h44, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        vec_d[1] = 16'hBEEF; vec_e[1] = {8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        vec_d[2] = 16'h0000; vec_e[2] = {8'h44, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        vec_d[3] = 16'hFFFF; vec_e[3] = {8'h44, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
        sel = 1'b0;
        for (int v = 0; v < 4; v++) begin
            e = vec_e[v];
            drive_read(vec_d[v]);
            capture();
            checks++;
            if (first_busy !== 1'b1 || first_tx !== 1'b0) begin
                errors++;
                $display("FAIL first_cycle_%h: busy=%b tx=%b, required busy=1 tx=0", vec_d[v], first_busy, first_tx);
            end
            checks++;
            if (busy_len !== 280) begin
                errors++;
                $display("FAIL busy_len_%h: %0d cycles, required 280", vec_d[v], busy_len);
            end
            checks++;
            if (frame_ok !== 1'b1 || width_ok !== 1'b1 || end_tx !== 1'b1) begin
                errors++;
                $display("FAIL framing_%h: frame_ok=%b width_ok=%b idle_tx=%b, required 1 1 1", vec_d[v], frame_ok, width_ok, end_tx);
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_bytes[i] !== e[55 - 8*i -: 8]) begin
                    errors++;
                    $display("FAIL byte%0d_%h: got %h, required %h", i, vec_d[v], rx_bytes[i], e[55 - 8*i -: 8]);
                end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_write_ignored();
        int bad;
        sel   = 1'b0;
        bad   = 0;
        data  = 16'hAAAA;
        rw    = 1'b1;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
            @(negedge clk);
        end
        rw = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL write_ignored: %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] e1;
        logic [55:0] e3;
        e1 = {8'h44, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
        e3 = {8'h44, 8'h33, 8'h33, 8'h33, 8'h33, 8'h0D, 8'h0A};
        sel = 1'b0;
        drive_read(16'h1111);
        fork
            capture();
            begin
                repeat (49) @(negedge clk);
                data  = 16'h2222;
                valid = 1'b1;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        checks++;
        if (busy_len !== 280) begin
            errors++;
            $display("FAIL drop_busy_len: %0d cycles, required 280", busy_len);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx_bytes[i] !== e1[55 - 8*i -: 8]) begin
                errors++;
                $display("FAIL drop_byte%0d: got %h, required %h", i, rx_bytes[i], e1[55 - 8*i -: 8]);
            end
        end
        // now at the first cycle busy reads 0: this request must be taken
        drive_read(16'h3333);
        capture();
        checks++;
        if (busy_len !== 280 || frame_ok !== 1'b1) begin
            errors++;
            $display("FAIL edge_accept: busy_len=%0d frame_ok=%b, required 280 1", busy_len, frame_ok);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx_bytes[i] !== e3[55 - 8*i -: 8]) begin
                errors++;
                $display("FAIL edge_byte%0d: got %h, required %h", i, rx_bytes[i], e3[55 - 8*i -: 8]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [55:0] e;
        e = {8'h44, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
        sel = 1'b0;
        drive_read(16'h1234);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b, required tx=1 busy=0", tx4, busy4);
        end
        rst = 1'b0;
        @(negedge clk);
        drive_read(16'h5678);
        capture();
        checks++;
        if (busy_len !== 280 || frame_ok !== 1'b1 || width_ok !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: busy_len=%0d frame_ok=%b width_ok=%b, required 280 1 1", busy_len, frame_ok, width_ok);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx_bytes[i] !== e[55 - 8*i -: 8]) begin
                errors++;
                $display("FAIL post_reset_byte%0d: got %h, required %h", i, rx_bytes[i], e[55 - 8*i -: 8]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_min_baud();
        logic [55:0] e;
        e = {8'h44, 8'h39, 8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
        sel = 1'b1;
        drive_read(16'h9ABC);
        capture();
        checks++;
        if (first_busy !== 1'b1 || first_tx !== 1'b0) begin
            errors++;
            $display("FAIL min_first_cycle: busy=%b tx=%b, required busy=1 tx=0", first_busy, first_tx);
        end
        checks++;
        if (busy_len !== 140) begin
            errors++;
            $display("FAIL min_busy_len: %0d cycles, required 140", busy_len);
        end
        checks++;
        if (frame_ok !== 1'b1 || width_ok !== 1'b1) begin
            errors++;
            $display("FAIL min_bit_width: frame_ok=%b width_ok=%b, required 1 1", frame_ok, width_ok);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx_bytes[i] !== e[55 - 8*i -: 8]) begin
                errors++;
                $display("FAIL min_byte%0d: got %h, required %h", i, rx_bytes[i], e[55 - 8*i -: 8]);
            end
        end
        sel = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read_patterns();
        test_write_ignored();
        test_back_to_back();
        test_reset_mid();
        test_min_baud();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_response_tx.md
Name: uart_response_tx

Overview:
- Egress path of the host debug link.
- Takes a completed bus read from the core chain, encodes it as ASCII response "D" + 4 uppercase hex digits + CR + LF, and serialises it on the UART tx pin at the configured baud.
- Sits between the last core's bus output and the top-level tx pin; mirrors the receive path that decodes host "R"/"W" requests.

Parameters:
CLOCKS_PER_BAUD, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
data_i  input  16  read data returned by the bus
rw_i  input  1  1 = write, 0 = read; only reads produce a response
valid_i  input  1  bus transaction completes this cycle
busy_o  output  1  response being transmitted; new requests dropped
tx  output  1  UART serial output, idle high

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - While rst is high, on the next edge: tx=1, busy_o=0, FSM=IDLE, baud counter=0, byte index=0, bit index=0.
  - Reset mid-frame aborts immediately; no partial byte completion.
- Accept:
  - In IDLE, if valid_i=1 and rw_i=0: latch data_i, go to SEND, busy_o=1 on the next cycle.
  - valid_i with rw_i=1 is ignored in every state.
  - valid_i while busy_o=1 is dropped; no queueing, latched data unchanged.
- Message:
  - 7 bytes in order: 0x44 'D', then hex of data[15:12], [11:8], [7:4], [3:0], then 0x0D, then 0x0A.
  - Hex encoding: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10). Uppercase only.
- Frame per byte:
  - Start bit 0, 8 data bits LSB first, stop bit 1. No parity. Each bit held exactly CLOCKS_PER_BAUD cycles.
  - Frames are back-to-back: the start bit of byte k+1 immediately follows the stop bit of byte k, with no idle cycles.
- Timing:
  - tx drops to 0 (start bit of 'D') on the first cycle busy_o=1, i.e. one cycle after the accepting edge.
  - The full response occupies exactly 70*CLOCKS_PER_BAUD cycles with busy_o=1.
  - busy_o returns to 0 on the cycle after the last stop-bit cycle.
  - A request in the same cycle busy_o reads 0 is accepted.
- FSM:
  - IDLE -> SEND on accept.
  - SEND iterates byte 0..6, each byte bit 0..9. Baud counter counts 0..CLOCKS_PER_BAUD-1, then wraps and advances the bit index.
  - Bit index 9 wrap advances the byte index. Byte 6 bit 9 wrap -> IDLE.
- Width rules:
  - Baud counter width is clog2(CLOCKS_PER_BAUD).
  - Byte index is 3 bits; bit index is 4 bits. Neither may wrap past its terminal value.
- tx is registered (glitch-free) and is 1 whenever in IDLE.

Test Plan:
- CLOCKS_PER_BAUD=4, one read of data_i=0x1234:
  - Bench UART model decodes 0x44 0x31 0x32 0x33 0x34 0x0D 0x0A.
  - busy_o high for exactly 280 cycles.
  - tx low on the first busy cycle.
- Read of 0xBEEF -> bytes 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A. Read of 0x0000 -> "D0000\r\n". Read of 0xFFFF -> "DFFFF\r\n".
- valid_i=1 with rw_i=1, data 0xAAAA -> tx stays 1 and busy_o stays 0 for 400 cycles.
- Read 0x1111, then read 0x2222 pulsed 50 cycles later while busy:
  - Only "D1111\r\n" is sent.
  - A third read 0x3333 on the cycle busy_o falls is sent in full as "D3333\r\n".
- rst asserted mid-transmission at cycle 100 of a 0x1234 response:
  - Next cycle tx=1, busy_o=0.
  - A subsequent read 0x5678 produces a clean "D5678\r\n".
- CLOCKS_PER_BAUD=2 (minimum): read 0x9ABC -> "D9ABC\r\n", busy_o high exactly 140 cycles, every bit exactly 2 cycles wide.
